// File: rtl/jc_counter_param.sv
// jc_counter_param: parametrised Johnson (twisted-ring) counter with 2*WIDTH states.
// Adds count enable, up/down direction, synchronous parallel load, a decoded phase
// index and a registered wrap pulse on the 2*WIDTH-1 <-> 0 boundary crossing.
// Optional build macro JC_SELF_CORRECT_EN: flags non-Johnson codes on 'illegal' and
// forces the next enabled step from such a code back to zero.
module jc_counter_param #(
   parameter  int unsigned WIDTH = 4,
   localparam int unsigned PHW   = $clog2(2 * WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [PHW-1:0]   phase,
   output logic             wrap,
   output logic             illegal
);

   // One extra bit so the constant 2*WIDTH is representable during the phase decode.
   localparam int unsigned CW = PHW + 1;

   // Code shown at phase 2*WIDTH-1; a forward step from here wraps to zero.
   localparam logic [WIDTH-1:0] LastCode = WIDTH'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic [CW-1:0]    ones;
   logic [CW-1:0]    phase_full;
   logic             illegal_w;

   // Population count of the counter register.
   always_comb begin
      ones = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         ones = ones + CW'(q_q[i]);
      end
   end

   // Phase decode: the low bit tells whether we are in the filling or draining half.
   always_comb begin
      phase_full = q_q[0] ? (CW'(2 * WIDTH) - ones) : ones;
   end

`ifdef JC_SELF_CORRECT_EN
   logic [WIDTH-2:0] edges;

   // A legal code has at most one adjacent-bit transition (linear, not circular).
   always_comb begin
      edges     = q_q[WIDTH-1:1] ^ q_q[WIDTH-2:0];
      illegal_w = ((edges & (edges - 1'b1)) != '0);
   end
`else
   assign illegal_w = 1'b0;
`endif

   // Next-state: load beats enable; enable steps in the sampled direction.
   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      if (load) begin
         q_d = load_val;
      end else if (en) begin
         if (illegal_w) begin
            q_d = '0;
         end else if (!dir) begin
            q_d    = {~q_q[0], q_q[WIDTH-1:1]};
            wrap_d = (q_q == LastCode);
         end else begin
            q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            wrap_d = (q_q == '0);
         end
      end
   end

   // State registers; reset clears both the count and any pending wrap pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
      end
   end

   assign q       = q_q;
   assign phase   = phase_full[PHW-1:0];
   assign wrap    = wrap_q;
   assign illegal = illegal_w;

endmodule
